// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-word encodings and the multiplier state enum.
package alu_pkg;

   // ALU control word {Ainvert, Binvert, operation[1:0]}
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the external ripple ALU for its adds.
// Optional macro ALU_MUL_ZERO_SKIP_EN: a zero operand skips CALC and finishes immediately.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   product_o,
   output logic [WIDTH-1:0]     alu_src1_o,
   output logic [WIDTH-1:0]     alu_src2_o,
   output logic [3:0]           alu_ctrl_o,
   input  logic [WIDTH-1:0]     alu_result_i,
   input  logic                 alu_cout_i
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   mul_state_t         r_state;
   mul_state_t         w_state_next;
   logic [WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_start_accept;
   logic               w_zero_op;

   assign w_start_accept = (r_state == IDLE) && start_i;

`ifdef ALU_MUL_ZERO_SKIP_EN
   assign w_zero_op = (a_i == '0) || (b_i == '0);
`else
   assign w_zero_op = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_next = w_zero_op ? DONE : CALC;
            end
         end
         CALC: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_next = DONE;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // The ALU carry-out becomes bit 2W of the shift so no overflow is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_m   <= '0;
         r_q   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_cnt <= '0;
      end else if (w_start_accept) begin
         r_m   <= a_i;
         r_q   <= b_i;
         r_hi  <= '0;
         r_lo  <= '0;
         r_cnt <= CNT_W'(WIDTH);
      end else if (r_state == CALC) begin
         r_hi  <= {alu_cout_i, alu_result_i[WIDTH-1:1]};
         r_lo  <= {alu_result_i[0], r_lo[WIDTH-1:1]};
         r_q   <= {1'b0, r_q[WIDTH-1:1]};
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   always_comb begin
      busy_o     = 1'b0;
      done_o     = 1'b0;
      alu_src1_o = '0;
      alu_src2_o = '0;
      alu_ctrl_o = ALU_ADD;
      case (r_state)
         CALC: begin
            busy_o     = 1'b1;
            alu_src1_o = r_hi;
            alu_src2_o = r_q[0] ? r_m : '0;
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   assign product_o = {r_hi, r_lo};

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural 32-bit ALU on the ALU ports.
`timescale 1ns/1ps
module tb_alu_mul_seq;
   import alu_pkg::*;

   localparam int WIDTH = 32;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [WIDTH-1:0]     a = '0;
   logic [WIDTH-1:0]     b = '0;
   logic                 busy_o;
   logic                 done_o;
   logic [2*WIDTH-1:0]   product_o;
   logic [WIDTH-1:0]     alu_src1;
   logic [WIDTH-1:0]     alu_src2;
   logic [3:0]           alu_ctrl;
   logic [WIDTH-1:0]     alu_result;
   logic                 alu_cout;

   always #5 clk = ~clk;

   alu_mul_seq #(.WIDTH(WIDTH)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .a_i          (a),
      .b_i          (b),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .product_o    (product_o),
      .alu_src1_o   (alu_src1),
      .alu_src2_o   (alu_src2),
      .alu_ctrl_o   (alu_ctrl),
      .alu_result_i (alu_result),
      .alu_cout_i   (alu_cout)
   );

   // Behavioural stand-in for the ripple ALU.
   always_comb begin
      logic [WIDTH:0] sum;
      sum        = '0;
      alu_result = '0;
      alu_cout   = 1'b0;
      case (alu_ctrl)
         ALU_AND: alu_result = alu_src1 & alu_src2;
         ALU_OR:  alu_result = alu_src1 | alu_src2;
         ALU_ADD: begin
            sum        = {1'b0, alu_src1} + {1'b0, alu_src2};
            alu_result = sum[WIDTH-1:0];
            alu_cout   = sum[WIDTH];
         end
         ALU_SUB, ALU_SLT: begin
            sum        = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 1;
            alu_result = (alu_ctrl == ALU_SLT) ? WIDTH'(sum[WIDTH-1]) : sum[WIDTH-1:0];
            alu_cout   = sum[WIDTH];
         end
         default: ;
      endcase
   end

   typedef struct {
      logic [2*WIDTH-1:0] prod;
      int                 cyc;
      int                 busy;
   } exp_t;

   exp_t               sb[$];
   int                 errors = 0;
   int                 checks = 0;
   int                 cyc_cnt = 0;
   int                 busy_cnt = 0;
   bit                 hold_chk = 0;
   logic [2*WIDTH-1:0] last_prod = '0;

   always @(posedge clk) begin
      cyc_cnt++;
      if (rst) begin
         busy_cnt = 0;
         hold_chk = 0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops an expectation at every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (hold_chk) begin
            check("product_hold", product_o, last_prod);
            hold_chk = 0;
         end
         if (busy_o) busy_cnt++;
         if (done_o) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("product", product_o, e.prod);
               check("done_cycle", 64'(cyc_cnt), 64'(e.cyc));
               check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
               $display("job done: product=%0h cycle=%0d busy=%0d", product_o, cyc_cnt, busy_cnt);
            end
            last_prod = product_o;
            hold_chk  = 1;
            busy_cnt  = 0;
         end
      end
   end

   function automatic int job_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef ALU_MUL_ZERO_SKIP_EN
      return (x == '0 || y == '0) ? 0 : WIDTH;
`else
      return (x == y && x == ~x) ? 0 : WIDTH;
`endif
   endfunction

   task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [2*WIDTH-1:0] req);
      exp_t e;
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      e.prod = req;
      e.busy = job_lat(x, y);
      e.cyc  = cyc_cnt + e.busy;
      sb.push_back(e);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < WIDTH + 10 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("done_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_done"}, 64'(done_o), 64'd0);
      check({tag, "_product"}, product_o, 64'd0);
      check({tag, "_src1"}, 64'(alu_src1), 64'd0);
      check({tag, "_src2"}, 64'(alu_src2), 64'd0);
      check({tag, "_ctrl"}, 64'(alu_ctrl), 64'(ALU_ADD));
   endtask

   initial begin
      int c;
      exp_t e;
      logic [WIDTH-1:0] ra, rb;

      repeat (3) @(negedge clk);
      reset_checks("reset");
      rst = 1'b0;
      @(negedge clk);
      reset_checks("idle");

      // Directed vectors
      issue(32'd3, 32'd5, 64'd15);
      drain();
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      drain();
      issue(32'd0, 32'd1234, 64'd0);
      drain();
      issue(32'd1, 32'd1, 64'd1);
      drain();

      // Back-to-back with start held; operands change while busy
      @(negedge clk);
      a = 32'd7;
      b = 32'd6;
      start = 1'b1;
      @(posedge clk);
      #1;
      c = cyc_cnt;
      e.prod = 64'd42;             e.busy = WIDTH; e.cyc = c + WIDTH;     sb.push_back(e);
      e.prod = 64'd10_000_000_000; e.busy = WIDTH; e.cyc = c + 2*WIDTH + 2; sb.push_back(e);
      @(negedge clk);
      a = 32'd100000;
      b = 32'd100000;
      for (int i = 0; i < 100 && cyc_cnt < c + WIDTH + 2; i++) begin
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      for (int i = 0; i < 2*WIDTH + 10 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("b2b_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end

      // Reset during CALC cycle 10: no done may follow
      @(negedge clk);
      a = 32'd9;
      b = 32'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset_checks("midcalc_rst");
      rst = 1'b0;
      repeat (WIDTH + 5) @(negedge clk);
      issue(32'd9, 32'd9, 64'd81);
      drain();

      // Random pairs against a 64-bit reference multiply
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom;
         rb = $urandom;
         if (n % 100 == 0) rb = '0;
         issue(ra, rb, {32'd0, ra} * {32'd0, rb});
         drain();
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
